// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared FSM state, address geometry and error helper for the data memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_LSB   = 2;

    localparam logic [ADDR_LSB-1:0] ALIGN_MASK = '1;

    // An access is bad when it is not word aligned or indexes past the last stored word.
    function automatic logic addr_err(input logic [31:0] addr, input int depth_words);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[ADDR_LSB-1:0] & ALIGN_MASK) != '0;
        out_of_range = {{ADDR_LSB{1'b0}}, addr[31:ADDR_LSB]} >= 32'(depth_words);
        return misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with byte-lane synchronous write and combinational read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [31:0]           wdata,
    input  logic [WORD_BYTES-1:0] be,
    output logic [31:0]           rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - single-outstanding load/store responder with wait states; DMEM_BYTE_EN adds byte enables
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
`ifdef DMEM_BYTE_EN
    input  logic [3:0]  be_i,
`endif
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic [3:0]  be_in;

    logic        accept;
    logic        err;
    logic        wr_en;
    logic [31:0] mem_rdata;

`ifdef DMEM_BYTE_EN
    assign be_in = be_i;
`else
    assign be_in = 4'hF;
`endif

    assign ready_o = (state == IDLE);
    assign accept  = req_i && ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                lat_we    <= we_i;
                lat_addr  <= addr_i;
                lat_wdata <= wdata_i;
                lat_be    <= be_in;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign err = addr_err(lat_addr, DEPTH_WORDS);

    // A reset landing on the RESP edge must not let the store through.
    assign wr_en = (state == RESP) && lat_we && !err && !rst_i;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk_i(clk_i),
        .we   (wr_en),
        .addr (lat_addr[AW+ADDR_LSB-1:ADDR_LSB]),
        .wdata(lat_wdata),
        .be   (lat_be),
        .rdata(mem_rdata)
    );

    assign valid_o = (state == RESP);
    assign err_o   = valid_o && err;
    assign rdata_o = (valid_o && !lat_we && !err) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - directed scoreboard bench for data_memory_responder
module tb_data_memory_responder;

    localparam int DEPTH_WORDS = 256;
`ifdef DMEM_BYTE_EN
    localparam int WAIT_CYCLES = 0;
`else
    localparam int WAIT_CYCLES = 2;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = 4'hF;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_responder #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .req_i  (req),
        .we_i   (we),
        .addr_i (addr),
        .wdata_i(wdata),
`ifdef DMEM_BYTE_EN
        .be_i   (be),
`endif
        .ready_o(ready_o),
        .valid_o(valid_o),
        .rdata_o(rdata_o),
        .err_o  (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_valid: observed=pulse expected=none (cycle %0d)", cyc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("resp_rdata", rdata_o, e.rdata);
                chk("resp_err", 32'(err_o), 32'(e.err));
                chk("resp_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Drives a request at a negedge, waits for acceptance, returns at the negedge after the accept edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                         input logic [31:0] exp_rd, input logic exp_err, input bit expect_resp,
                         input bit hold, output int acc);
        int n = 0;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        be    = b;
        while (ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 50) else begin
            errors++;
            $error("FAIL accept_timeout: observed=no accept expected=accept within 50 cycles");
        end
        acc = cyc;
        if (expect_resp) sb.push_back('{exp_rd, exp_err, cyc + WAIT_CYCLES + 1});
        @(negedge clk);
        if (!hold) req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain: observed=%0d pending expected=0 pending", sb.size());
        end
    endtask

    initial begin
        int acc;
        int accs[6];
        logic [31:0] clr[4];
        logic        cw[6];
        logic [31:0] ca[6];
        logic [31:0] cd[6];
        logic [31:0] ce[6];

        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(ready_o), 32'd1);
        chk("reset_valid", 32'(valid_o), 32'd0);
        chk("reset_rdata", rdata_o, 32'h0);
        chk("reset_err", 32'(err_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(ready_o), 32'd1);
        chk("idle_valid", 32'(valid_o), 32'd0);

        clr = '{32'h0, 32'h20, 32'h24, 32'h28};
        foreach (clr[i]) issue(1'b1, clr[i], 32'h0, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        issue(1'b1, 32'h0, 32'h1111_1111, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, acc);

        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        issue(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, acc);
        issue(1'b0, 32'h12, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1, 1'b0, acc);
        issue(1'b0, 32'h400, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1, 1'b0, acc);
        issue(1'b1, 32'h400, 32'h5555_5555, 4'hF, 32'h0, 1'b1, 1'b1, 1'b0, acc);
        issue(1'b0, 32'h0, 32'h0, 4'hF, 32'h1111_1111, 1'b0, 1'b1, 1'b0, acc);
        issue(1'b1, 32'h3FC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        issue(1'b0, 32'h3FC, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, acc);
        drain();

        cw = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ca = '{32'h40, 32'h40, 32'h44, 32'h44, 32'h40, 32'h40};
        cd = '{32'hA1A1_0001, 32'h0, 32'hA2A2_0002, 32'h0, 32'hB0B0_0003, 32'h0};
        ce = '{32'h0, 32'hA1A1_0001, 32'h0, 32'hA2A2_0002, 32'h0, 32'hB0B0_0003};
        for (int i = 0; i < 6; i++) begin
            issue(cw[i], ca[i], cd[i], 4'hF, ce[i], 1'b0, 1'b1, (i < 5), accs[i]);
        end
        for (int i = 1; i < 6; i++) begin
            chk("b2b_spacing", 32'(accs[i] - accs[i-1]), 32'(WAIT_CYCLES + 2));
        end
        drain();

`ifndef DMEM_BYTE_EN
        issue(1'b1, 32'h20, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_wait_valid", 32'(valid_o), 32'd0);
        chk("abort_wait_ready", 32'(ready_o), 32'd1);
        repeat (6) @(negedge clk);
        issue(1'b0, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        drain();
`endif

        issue(1'b1, 32'h24, 32'h9999_AAAA, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        repeat (WAIT_CYCLES) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_resp_valid", 32'(valid_o), 32'd0);
        issue(1'b0, 32'h24, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        drain();

        @(negedge clk);
        rst   = 1'b1;
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h28;
        wdata = 32'h7777_7777;
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;
        chk("req_in_reset_ready", 32'(ready_o), 32'd1);
        repeat (5) @(negedge clk);
        issue(1'b0, 32'h28, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        drain();

`ifdef DMEM_BYTE_EN
        issue(1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        issue(1'b1, 32'h8, 32'h0000_00AA, 4'h1, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        issue(1'b0, 32'h8, 32'h0, 4'h0, 32'hFFFF_FFAA, 1'b0, 1'b1, 1'b0, acc);
        issue(1'b1, 32'h8, 32'h1234_5678, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        issue(1'b0, 32'h8, 32'h0, 4'hF, 32'hFFFF_FFAA, 1'b0, 1'b1, 1'b0, acc);
        drain();
`endif

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
